id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register stage directly downstream of the opcode decoder.
//  Captures writeBack (2b), memAccess (3b) and calculation (4b) control bundles plus decoded operands each clock.
//  Contains load-use hazard detection: stalls upstream (PC, IF/ID) and inserts a bubble into EX.
//  Accepts a branch flush from MEM.
// PARAMETERS
//  DATA_WIDTH      32  width of register operands, sign-extended immediate, pcPlus4
//  REG_ADDR_WIDTH   5  width of register specifiers rs/rt/rd
// PORTS
//  clk                   in   1   single clock, rising edge
//  reset                 in   1   asynchronous, active-high reset
//  writeBackControlIn    in   2   {regWrite, memToReg} from decoder
//  memAccessControlIn    in   3   {branch, memRead, memWrite} from decoder
//  calculationControlIn  in   4   {regDst, aluOp1, aluOp0, aluSrc} from decoder
//  idValid               in   1   ID holds a real instruction
//  idUsesRt              in   1   ID instruction reads rt (R-format, store, beq)
//  readData1In/2In       in   DW  register file read ports
//  signExtIn             in   DW  sign-extended immediate
//  pcPlus4In             in   DW  PC+4 of ID instruction
//  rsIn/rtIn/rdIn        in   RA  register specifiers
//  flush                 in   1   branch taken in MEM; kill ID and EX contents
//  writeBackControlOut   out  2   registered
//  memAccessControlOut   out  3   registered
//  calculationControlOut out  4   registered
//  exValid               out  1   EX slot holds a real instruction
//  readData1Out/2Out, signExtOut, pcPlus4Out  out DW  registered
//  rsOut/rtOut/rdOut     out  RA  registered
//  stall                 out  1   combinational; hold PC and IF/ID this cycle
// BEHAVIOUR
//  - Reset (async): all registered outputs 0; exValid=0, so EX holds a bubble; release takes effect on the next clk edge.
//  - Latency: 1 cycle; ID values appear on *Out after the next rising edge.
//  - Hazard: stall = exValid & memAccessControlOut[1] & idValid & ~flush
//      & (rtOut==rsIn | (idUsesRt & rtOut==rtIn)).
//    Register 0 is not special-cased; a stall on $0 is permitted and harmless.
//  - Each edge, exactly one of three actions, in priority order:
//      1 flush=1 : load bubble. All control outputs 0, exValid=0.
//      2 stall=1 : load bubble; upstream holds the same ID instruction.
//        The stall clears next cycle because the load has left EX (exValid or memRead drops).
//      3 else    : capture all inputs; exValid <= idValid.
//  - On a bubble, data/specifier registers may capture inputs but control outputs must be 0, so no regWrite/memWrite/branch leaks.
//  - idValid=0 with no flush or stall: control captured as 0, exValid=0.
//  - Simultaneous flush and hazard: flush wins and stall=0, so fetch redirects without a hold.
//  - Back-to-back loads to the same rt: at most one stall cycle per dependent consumer.
//  - Reset mid-stall: stall drops immediately, because exValid goes to 0.
// CONFIGURATION
//  ID_EX_STALL_COUNT_EN defined:
//   - adds output stallCount[15:0].
//   - Counter is reset to 0, increments on each edge where stall=1, and saturates at 16'hFFFF.
//  Undefined: no port, no counter logic.
// STRUCTURE
//  microprocessor_pkg: control-bundle widths (WB_W=2, MEM_W=3, CALC_W=4), bit indices (MEM_READ_BIT=1 etc.), bubble constants (all zero).
//  Sub-module hazard_detect_unit: pure combinational stall equation; register body inline.
// TESTING
//  1 reset asserted mid-run, control inputs nonzero -> all outputs 0 and exValid=0 asynchronously; stall=0.
//  2 R-format ctrl {2'b10,3'b000,4'b1100}, idValid=1 -> same values on outputs after 1 edge; exValid=1.
//  3 lw rt=5 in EX, ID add rs=5 -> stall=1 for exactly 1 cycle; EX bubble (ctrl 0); add enters EX on the following edge.
//  4 lw rt=5 in EX, ID lw rs=3 rt=5 with idUsesRt=0 -> stall=0; instruction passes.
//  5 hazard plus flush in the same cycle -> stall=0; next EX ctrl all 0, exValid=0.
//  6 ID_EX_STALL_COUNT_EN: force 3 stalls -> stallCount=3; preload 16'hFFFF and stall -> stays 16'hFFFF.

Source files
------------

// File: rtl/microprocessor_pkg.sv
// Shared definitions for the ID/EX stage: control-bundle widths, bit
// positions inside the bundles and the all-zero bubble encodings.
package microprocessor_pkg;

    localparam int WB_W   = 2;  // {regWrite, memToReg}
    localparam int MEM_W  = 3;  // {branch, memRead, memWrite}
    localparam int CALC_W = 4;  // {regDst, aluOp1, aluOp0, aluSrc}

    localparam int MEM_READ_BIT = 1;

    localparam logic [WB_W-1:0]   WB_BUBBLE   = '0;
    localparam logic [MEM_W-1:0]  MEM_BUBBLE  = '0;
    localparam logic [CALC_W-1:0] CALC_BUBBLE = '0;

    // A load is the only instruction whose result is late enough to need a stall.
    function automatic logic is_load(input logic [MEM_W-1:0] mem_ctrl);
        return mem_ctrl[MEM_READ_BIT];
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between the decoder side (ID) and the ID/EX register.
// master: the decode stage / testbench that drives ID values and flush.
// slave : the ID/EX register that returns registered EX values and stall.
// Handshake: there is no valid/ready pair; idValid marks a real ID
// instruction, exValid marks a real EX instruction, and stall (combinational)
// tells upstream to hold PC and IF/ID during the current cycle.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    // ID side
    logic [1:0]                writeBackControlIn;
    logic [2:0]                memAccessControlIn;
    logic [3:0]                calculationControlIn;
    logic                      idValid;
    logic                      idUsesRt;
    logic [DATA_WIDTH-1:0]     readData1In;
    logic [DATA_WIDTH-1:0]     readData2In;
    logic [DATA_WIDTH-1:0]     signExtIn;
    logic [DATA_WIDTH-1:0]     pcPlus4In;
    logic [REG_ADDR_WIDTH-1:0] rsIn;
    logic [REG_ADDR_WIDTH-1:0] rtIn;
    logic [REG_ADDR_WIDTH-1:0] rdIn;
    logic                      flush;
    // EX side
    logic [1:0]                writeBackControlOut;
    logic [2:0]                memAccessControlOut;
    logic [3:0]                calculationControlOut;
    logic                      exValid;
    logic [DATA_WIDTH-1:0]     readData1Out;
    logic [DATA_WIDTH-1:0]     readData2Out;
    logic [DATA_WIDTH-1:0]     signExtOut;
    logic [DATA_WIDTH-1:0]     pcPlus4Out;
    logic [REG_ADDR_WIDTH-1:0] rsOut;
    logic [REG_ADDR_WIDTH-1:0] rtOut;
    logic [REG_ADDR_WIDTH-1:0] rdOut;
    logic                      stall;

    modport master (
        output writeBackControlIn, memAccessControlIn, calculationControlIn,
               idValid, idUsesRt, readData1In, readData2In, signExtIn,
               pcPlus4In, rsIn, rtIn, rdIn, flush,
        input  writeBackControlOut, memAccessControlOut, calculationControlOut,
               exValid, readData1Out, readData2Out, signExtOut, pcPlus4Out,
               rsOut, rtOut, rdOut, stall
    );

    modport slave (
        input  writeBackControlIn, memAccessControlIn, calculationControlIn,
               idValid, idUsesRt, readData1In, readData2In, signExtIn,
               pcPlus4In, rsIn, rtIn, rdIn, flush,
        output writeBackControlOut, memAccessControlOut, calculationControlOut,
               exValid, readData1Out, readData2Out, signExtOut, pcPlus4Out,
               rsOut, rtOut, rdOut, stall
    );
endinterface

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detector: purely combinational. Raises stall when the
// instruction in EX is a load whose rt is a source of the ID instruction.
// A flush kills ID anyway, so it suppresses the stall and fetch redirects.
module hazard_detect_unit #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      ex_valid_i,
    input  logic                      ex_mem_read_i,
    input  logic                      id_valid_i,
    input  logic                      id_uses_rt_i,
    input  logic                      flush_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_i,
    output logic                      stall_o
);
    // Register 0 is deliberately not special-cased; a stall on $0 is harmless.
    always_comb begin
        stall_o = ex_valid_i & ex_mem_read_i & id_valid_i & ~flush_i
                & ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard bubble insertion and MEM flush.
// Optional feature: define ID_EX_STALL_COUNT_EN to add a saturating 16-bit
// stallCount output counting edges on which stall was high.
module id_ex_stage
    import microprocessor_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
`ifdef ID_EX_STALL_COUNT_EN
    ,
    output logic [15:0]   stallCount
`endif
);
    logic [WB_W-1:0]           wb_q,   wb_d;
    logic [MEM_W-1:0]          mem_q,  mem_d;
    logic [CALC_W-1:0]         calc_q, calc_d;
    logic                      valid_q, valid_d;
    logic [DATA_WIDTH-1:0]     rd1_q, rd2_q, sext_q, pc4_q;
    logic [REG_ADDR_WIDTH-1:0] rs_q, rt_q, rd_q;
    logic                      stall_w;

    hazard_detect_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hazard (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (is_load(mem_q)),
        .id_valid_i    (bus.idValid),
        .id_uses_rt_i  (bus.idUsesRt),
        .flush_i       (bus.flush),
        .ex_rt_i       (rt_q),
        .id_rs_i       (bus.rsIn),
        .id_rt_i       (bus.rtIn),
        .stall_o       (stall_w)
    );

    // Next control: flush or stall load a bubble; otherwise capture, with
    // an invalid ID instruction also producing zero control.
    always_comb begin
        wb_d    = WB_BUBBLE;
        mem_d   = MEM_BUBBLE;
        calc_d  = CALC_BUBBLE;
        valid_d = 1'b0;
        if (!bus.flush && !stall_w && bus.idValid) begin
            wb_d    = bus.writeBackControlIn;
            mem_d   = bus.memAccessControlIn;
            calc_d  = bus.calculationControlIn;
            valid_d = 1'b1;
        end
    end

    // Pipeline register; data/specifiers capture every edge, bubbles only zero control.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q    <= WB_BUBBLE;
            mem_q   <= MEM_BUBBLE;
            calc_q  <= CALC_BUBBLE;
            valid_q <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            sext_q  <= '0;
            pc4_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            wb_q    <= wb_d;
            mem_q   <= mem_d;
            calc_q  <= calc_d;
            valid_q <= valid_d;
            rd1_q   <= bus.readData1In;
            rd2_q   <= bus.readData2In;
            sext_q  <= bus.signExtIn;
            pc4_q   <= bus.pcPlus4In;
            rs_q    <= bus.rsIn;
            rt_q    <= bus.rtIn;
            rd_q    <= bus.rdIn;
        end
    end

`ifdef ID_EX_STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_w && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stallCount = stall_cnt_q;
`endif

    assign bus.writeBackControlOut   = wb_q;
    assign bus.memAccessControlOut   = mem_q;
    assign bus.calculationControlOut = calc_q;
    assign bus.exValid               = valid_q;
    assign bus.readData1Out          = rd1_q;
    assign bus.readData2Out          = rd2_q;
    assign bus.signExtOut            = sext_q;
    assign bus.pcPlus4Out            = pc4_q;
    assign bus.rsOut                 = rs_q;
    assign bus.rtOut                 = rt_q;
    assign bus.rdOut                 = rd_q;
    assign bus.stall                 = stall_w;
endmodule
